// File: rtl/serial_to_parallel_hs.sv
// Byte-to-word packer with ready/valid output, holding register and sticky overflow.
// Optional partial-word timeout enabled by defining STP_TIMEOUT_EN.
module serial_to_parallel_hs #(
  parameter int N              = 32,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int BYTES         = N / 8,
  localparam int CW            = $clog2(BYTES)
) (
  input  logic          iCE_CLK,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          rx_ready,
  input  logic          clear,
  output logic [N-1:0]  tx_bytes,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [CW-1:0] byte_cnt,
  output logic          overflow,
  output logic          timeout
);

  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  if (N % 8 != 0 || N < 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("serial_to_parallel_hs: illegal parameter set");
  end

  logic [N-1:0]  acc_q, acc_d, merged;
  logic [N-1:0]  tx_q, tx_d;
  logic [CW-1:0] cnt_q, cnt_d, lane;
  logic          txv_q, txv_d;
  logic          ovf_q, ovf_d;
  logic          stall, take;

  // Final lane of a word can only be written when the holding register is free or draining.
  assign stall    = (cnt_q == LAST) && txv_q && !tx_ready;
  assign take     = rx_valid && !stall && !clear;
  assign lane     = MSB_FIRST ? (LAST - cnt_q) : cnt_q;
  assign rx_ready = !stall;

  always_comb begin
    merged = acc_q;
    for (int i = 0; i < BYTES; i++)
      if (lane == CW'(i)) merged[i*8 +: 8] = rx_byte;
  end

`ifdef STP_TIMEOUT_EN
  localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] TLAST = IW'(TIMEOUT_CYCLES - 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          to_q, to_d;
`endif

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    tx_d  = tx_q;
    txv_d = txv_q;
    ovf_d = ovf_q;
    if (txv_q && tx_ready) txv_d = 1'b0;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (rx_valid && stall) ovf_d = 1'b1;
      if (take) begin
        if (cnt_q == LAST) begin
          tx_d  = merged;
          txv_d = 1'b1;
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = merged;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
`ifdef STP_TIMEOUT_EN
    idle_d = idle_q;
    to_d   = 1'b0;
    // Idle count freezes while stalled so a blocked consumer never costs a partial word.
    if (clear || take || cnt_q == '0) begin
      idle_d = '0;
    end else if (!stall) begin
      if (idle_q == TLAST) begin
        idle_d = '0;
        acc_d  = '0;
        cnt_d  = '0;
        to_d   = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      tx_q  <= '0;
      txv_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      tx_q  <= tx_d;
      txv_q <= txv_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef STP_TIMEOUT_EN
  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign tx_bytes = tx_q;
  assign tx_valid = txv_q;
  assign byte_cnt = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_to_parallel_hs.sv
// Directed bench: MSB-first and LSB-first instances share stimulus; expected values are hand-computed.
module tb_serial_to_parallel_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid, clear, tx_ready;
  logic [7:0]  rx_byte;

  logic        rdy_m, txv_m, ovf_m, to_m;
  logic [31:0] word_m;
  logic [1:0]  cnt_m;
  logic        rdy_l, txv_l, ovf_l, to_l;
  logic [31:0] word_l;
  logic [1:0]  cnt_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_to_parallel_hs #(.N(32), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(16)) u_msb (
    .iCE_CLK(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rdy_m),
    .clear(clear), .tx_bytes(word_m), .tx_valid(txv_m), .tx_ready(tx_ready),
    .byte_cnt(cnt_m), .overflow(ovf_m), .timeout(to_m));

  serial_to_parallel_hs #(.N(32), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(16)) u_lsb (
    .iCE_CLK(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rdy_l),
    .clear(clear), .tx_bytes(word_l), .tx_valid(txv_l), .tx_ready(tx_ready),
    .byte_cnt(cnt_l), .overflow(ovf_l), .timeout(to_l));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    cyc();
    rx_valid = 1'b0;
  endtask

  logic [7:0]  t1 [4]   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [31:0] strm [3] = '{32'h10111213, 32'h14151617, 32'h18191A1B};

  initial begin
    rst_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; clear = 1'b0; tx_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_word", word_m, 32'h0);
    chk("rst_txv", txv_m, 1'b0);
    chk("rst_cnt", cnt_m, 2'd0);
    chk("rst_ovf", ovf_m, 1'b0);
    chk("rst_to", to_m, 1'b0);
    chk("rst_rdy", rdy_m, 1'b1);
    cyc();
    rst_n = 1'b1;

    // basic packing, both byte orders
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_byte  = t1[i];
      chk("t1_cnt_step", cnt_l, 64'(i));
      cyc();
    end
    rx_valid = 1'b0;
    chk("t1_txv", txv_m, 1'b1);
    chk("t1_word_msb", word_m, 32'hAABBCCDD);
    chk("t1_word_lsb", word_l, 32'hDDCCBBAA);
    chk("t1_cnt_wrap", cnt_l, 2'd0);
    cyc();
    chk("t1_txv_drop", txv_m, 1'b0);

    // stall, drop, overflow, clear
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'(i);
      if (i == 8) chk("t2_rdy_low", rdy_m, 1'b0);
      cyc();
    end
    rx_valid = 1'b0;
    chk("t2_ovf", ovf_m, 1'b1);
    chk("t2_txv", txv_m, 1'b1);
    chk("t2_word_msb", word_m, 32'h01020304);
    chk("t2_word_lsb", word_l, 32'h04030201);
    chk("t2_cnt", cnt_m, 2'd3);
    tx_ready = 1'b1;
    #1 chk("t2_rdy_high", rdy_m, 1'b1);
    cyc();
    chk("t2_drained", txv_m, 1'b0);
    chk("t2_cnt_hold", cnt_m, 2'd3);
    chk("t2_ovf_sticky", ovf_m, 1'b1);
    clear = 1'b1; rx_valid = 1'b1; rx_byte = 8'h99;
    cyc();
    clear = 1'b0; rx_valid = 1'b0;
    chk("t2_clr_ovf", ovf_m, 1'b0);
    chk("t2_clr_cnt", cnt_m, 2'd0);
    chk("t2_clr_txv", txv_m, 1'b0);

    // final byte arrives on the same edge the held word drains
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'h21 + 8'(i);
      if (i == 7) tx_ready = 1'b1;
      cyc();
    end
    rx_valid = 1'b0;
    chk("t3_txv", txv_m, 1'b1);
    chk("t3_word", word_m, 32'h25262728);
    chk("t3_ovf", ovf_m, 1'b0);
    cyc();
    chk("t3_drained", txv_m, 1'b0);

    // full-rate stream
    tx_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'h10 + 8'(k - 1);
      cyc();
      chk("t4_txv", txv_m, (k % 4) == 0);
      chk("t4_ovf", ovf_m, 1'b0);
      if (k % 4 == 0) chk("t4_word", word_m, strm[k/4 - 1]);
    end
    rx_valid = 1'b0;

    // async reset mid-word
    send(8'hAA);
    send(8'hBB);
    chk("t5_cnt_pre", cnt_m, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_word", word_m, 32'h0);
    chk("t5_rst_cnt", cnt_m, 2'd0);
    chk("t5_rst_txv", txv_m, 1'b0);
    chk("t5_rst_ovf", ovf_m, 1'b0);
    cyc();
    rst_n = 1'b1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t5_txv", txv_m, 1'b1);
    chk("t5_word", word_m, 32'h11223344);
    cyc();

    // partial-word timeout
    send(8'hAA);
    chk("t6_cnt_one", cnt_m, 2'd1);
`ifdef STP_TIMEOUT_EN
    repeat (15) cyc();
    chk("t6_to_early", to_m, 1'b0);
    chk("t6_cnt_early", cnt_m, 2'd1);
    cyc();
    chk("t6_to_pulse", to_m, 1'b1);
    chk("t6_cnt_zero", cnt_m, 2'd0);
    cyc();
    chk("t6_to_end", to_m, 1'b0);
`else
    repeat (20) cyc();
    chk("t6_to_tied", to_m, 1'b0);
    chk("t6_cnt_held", cnt_m, 2'd1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
`endif
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t6_word_msb", word_m, 32'h01020304);
    chk("t6_word_lsb", word_l, 32'h04030201);
    chk("t6_txv", txv_m, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
